// File: rtl/dct_pkg.sv
// Shared defaults for the streaming DCT butterfly front end.
package dct_pkg;

    localparam int unsigned InWDef    = 15;
    localparam int unsigned FracWDef  = 10;
    localparam int unsigned OutWDef   = 18;
    localparam int unsigned PointsDef = 8;
    localparam int unsigned LanesDef  = PointsDef / 2;

    function automatic bit points_legal(input int unsigned p);
        return (p == 4) || (p == 8) || (p == 16);
    endfunction

endpackage

// File: rtl/dct_bfly_pair.sv
// One butterfly lane: sign-extend both operands, then exact sum and difference.
module dct_bfly_pair #(
    parameter int unsigned IN_W  = 15,
    parameter int unsigned OUT_W = 18
) (
    input  logic [IN_W-1:0]  a_i,
    input  logic [IN_W-1:0]  b_i,
    output logic [OUT_W-1:0] sum_o,
    output logic [OUT_W-1:0] diff_o
);

    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;

    assign a_ext  = {{(OUT_W - IN_W){a_i[IN_W-1]}}, a_i};
    assign b_ext  = {{(OUT_W - IN_W){b_i[IN_W-1]}}, b_i};
    assign sum_o  = a_ext + b_ext;
    assign diff_o = a_ext - b_ext;

endmodule

// File: rtl/dct_bfly_stream.sv
// Streaming first butterfly stage: buffers one frame of samples and emits all
// sum/difference lanes in the cycle after the last sample arrives.
module dct_bfly_stream
    import dct_pkg::*;
#(
    parameter int unsigned IN_W   = InWDef,
    parameter int unsigned FRAC_W = FracWDef,
    parameter int unsigned OUT_W  = OutWDef,
    parameter int unsigned POINTS = PointsDef
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IN_W-1:0]              in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [(POINTS/2)*OUT_W-1:0]  out_sum,
    output logic [(POINTS/2)*OUT_W-1:0]  out_diff,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int unsigned Lanes = POINTS / 2;
    localparam int unsigned IdxW  = $clog2(POINTS);

    if (!points_legal(POINTS) || (OUT_W < IN_W + 1) || (FRAC_W >= IN_W)) begin : g_bad_params
        $error("dct_bfly_stream: illegal parameter combination");
    end

    logic [IdxW-1:0]        idx_q, idx_d;
    logic                   out_valid_q, out_valid_d;
    logic [Lanes*OUT_W-1:0] out_sum_q, out_diff_q;
    logic [Lanes*OUT_W-1:0] sum_w, diff_w;
    // Only x_0..x_(POINTS-2) are stored; the last sample feeds lane 0 directly.
    logic [IN_W-1:0]        buf_q [POINTS-1];

    logic last, accept, complete;

    assign last     = (idx_q == IdxW'(POINTS - 1));
    assign in_ready = rst && !(last && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign complete = accept && last;

    always_comb begin
        idx_d = idx_q;
        if (flush) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = last ? '0 : idx_q + IdxW'(1);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (complete) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_diff_q  <= '0;
            for (int unsigned i = 0; i < POINTS - 1; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            if (accept && !last) begin
                buf_q[idx_q] <= in_data;
            end
            if (complete) begin
                out_sum_q  <= sum_w;
                out_diff_q <= diff_w;
            end
        end
    end

    for (genvar k = 0; k < Lanes; k++) begin : g_lane
        logic [IN_W-1:0] b;
        if (k == 0) begin : g_first
            assign b = in_data;
        end else begin : g_rest
            assign b = buf_q[POINTS-1-k];
        end
        dct_bfly_pair #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_pair (
            .a_i    (buf_q[k]),
            .b_i    (b),
            .sum_o  (sum_w[k*OUT_W +: OUT_W]),
            .diff_o (diff_w[k*OUT_W +: OUT_W])
        );
    end

    assign out_sum   = out_sum_q;
    assign out_diff  = out_diff_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dct_bfly_stream.sv
// Directed bench for dct_bfly_stream with an 8-point and a 4-point instance.
module tb_dct_bfly_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] in_data;
    logic        in_valid, flush, out_ready, in_ready, out_valid;
    logic [71:0] out_sum, out_diff;

    logic [14:0] in_data4;
    logic        in_valid4, out_ready4, in_ready4, out_valid4;
    logic [35:0] out_sum4, out_diff4;
    logic        flush4 = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dct_bfly_stream u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_sum   (out_sum),
        .out_diff  (out_diff),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    dct_bfly_stream #(.POINTS(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .flush     (flush4),
        .out_sum   (out_sum4),
        .out_diff  (out_diff4),
        .out_valid (out_valid4),
        .out_ready (out_ready4)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one sample to the 8-point instance for exactly one edge.
    task automatic send8(input logic [14:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [14:0] fx(input int v);
        return 15'(v * 1024);
    endfunction

    localparam logic [71:0] RampSum  = {4{18'h02400}};
    localparam logic [71:0] RampDiff = {18'h3FC00, 18'h3F400, 18'h3EC00, 18'h3E400};

    initial begin
        rst = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_data4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 72'(in_ready), 72'd0);
        chk("reset_out_valid", 72'(out_valid), 72'd0);
        chk("reset_out_sum", out_sum, 72'd0);
        chk("reset_out_diff", out_diff, 72'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", 72'(in_ready), 72'd1);

        // Ramp 1.0..8.0
        for (int i = 0; i < 8; i++) begin
            chk("ramp_valid_low", 72'(out_valid), 72'd0);
            send8(fx(i + 1));
        end
        chk("ramp_valid", 72'(out_valid), 72'd1);
        chk("ramp_sum", out_sum, RampSum);
        chk("ramp_diff", out_diff, RampDiff);
        @(posedge clk);
        #1;
        chk("ramp_valid_clear", 72'(out_valid), 72'd0);

        // Extremes
        for (int i = 0; i < 8; i++) send8((i < 4) ? 15'h4000 : 15'h3FFF);
        chk("ext_valid", 72'(out_valid), 72'd1);
        chk("ext_sum", out_sum, {4{18'h3FFFF}});
        chk("ext_diff", out_diff, {4{18'h38001}});
        @(posedge clk);
        #1;

        // Backpressure: ramp frame then a frame of 2.0, consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send8(fx(i + 1));
        for (int i = 0; i < 7; i++) begin
            chk("bp_in_ready_open", 72'(in_ready), 72'd1);
            send8(fx(2));
        end
        in_data  = fx(2);
        in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            chk("bp_in_ready_blocked", 72'(in_ready), 72'd0);
            chk("bp_hold_valid", 72'(out_valid), 72'd1);
            chk("bp_hold_sum", out_sum, RampSum);
            chk("bp_hold_diff", out_diff, RampDiff);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 72'(in_ready), 72'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_valid", 72'(out_valid), 72'd1);
        chk("bp_second_sum", out_sum, {4{18'h01000}});
        chk("bp_second_diff", out_diff, 72'd0);
        @(posedge clk);
        #1;
        chk("bp_valid_clear", 72'(out_valid), 72'd0);

        // Flush after three samples, with a sample offered on the flush cycle
        for (int i = 0; i < 3; i++) send8(fx(5));
        flush = 1'b1;
        send8(fx(7));
        flush = 1'b0;
        chk("flush_valid_low", 72'(out_valid), 72'd0);
        for (int i = 0; i < 7; i++) begin
            send8(fx(1));
            chk("flush_no_early_frame", 72'(out_valid), 72'd0);
        end
        send8(fx(1));
        chk("flush_valid", 72'(out_valid), 72'd1);
        chk("flush_sum", out_sum, {4{18'h00800}});
        chk("flush_diff", out_diff, 72'd0);
        @(posedge clk);
        #1;
        chk("flush_single_frame", 72'(out_valid), 72'd0);

        // Reset mid-frame with a held result outstanding
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send8(fx(i + 1));
        for (int i = 0; i < 5; i++) send8(fx(3));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", 72'(in_ready), 72'd0);
        chk("midrst_valid", 72'(out_valid), 72'd0);
        chk("midrst_sum", out_sum, 72'd0);
        chk("midrst_diff", out_diff, 72'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send8(fx(-(i + 1)));
        chk("midrst_frame_valid", 72'(out_valid), 72'd1);
        chk("midrst_frame_sum", out_sum, {4{18'h3DC00}});
        chk("midrst_frame_diff", out_diff, {18'h00400, 18'h00C00, 18'h01400, 18'h01C00});

        // 4-point instance: ramp 1.0..4.0
        chk("p4_idle_valid", 72'(out_valid4), 72'd0);
        for (int i = 0; i < 4; i++) begin
            in_data4  = fx(i + 1);
            in_valid4 = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid4 = 1'b0;
        chk("p4_valid", 72'(out_valid4), 72'd1);
        chk("p4_sum", 72'(out_sum4), 72'({2{18'h01400}}));
        chk("p4_diff", 72'(out_diff4), 72'({18'h3FC00, 18'h3F400}));
        @(posedge clk);
        #1;
        chk("p4_valid_clear", 72'(out_valid4), 72'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
